ballot_controller: RTL
======================

Name: ballot_controller

Overview:
- Sequences one voting cycle of the EVM: the control unit issues a ballot, the ballot unit accepts exactly one candidate press, the vote is tallied, and the unit is locked for a hold period.
- Drives the busy status that the downstream ready-lamp inversion consumes.
- Owns the per-candidate tally registers and a registered read-out port for result display after the poll closes.

Parameters:
- NUM_CAND, 4, number of candidate buttons (2..16).
- CNT_W, 8, width of each tally counter and of the total counter.
- HOLD_CYCLES, 8, number of lockout cycles after a recorded vote (≥1).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- ballot_req  input  1  control-unit ballot button; synchronous pulse or level, rising edge used
- close_poll  input  1  control-unit close command; level
- vote_btn  input  NUM_CAND  candidate buttons; synchronous, debounced, active-high
- rd_sel  input  $clog2(NUM_CAND)  tally index to read
- busy  output  1  high whenever a ballot is in progress (ARMED/RECORD/HOLD)
- ballot_en  output  1  ballot-unit enable; high only in ARMED
- vote_ack  output  1  one-cycle pulse when a vote is recorded
- poll_closed  output  1  high in CLOSED
- rd_count  output  CNT_W  tally of candidate rd_sel, registered
- total_count  output  CNT_W  total recorded votes
- sat_flag  output  1  sticky; set when any counter saturates

Behaviour:
- Reset: state IDLE; all tallies, total_count, rd_count, sat_flag = 0; busy, ballot_en, vote_ack, poll_closed = 0. Edge-detect registers = 0.
- Edge detection: req_rise = ballot_req & ~ballot_req_q; btn_rise = vote_btn & ~vote_btn_q. The _q registers update every cycle in all states.
- IDLE:
  - close_poll = 1 → CLOSED. close_poll has priority over req_rise in the same cycle.
  - Otherwise req_rise → ARMED.
- ARMED:
  - ballot_en = busy = 1.
  - Accept a press when btn_rise is nonzero and vote_btn is exactly one-hot (i.e. vote_btn == btn_rise and popcount == 1) → RECORD, latching the index.
  - Simultaneous or overlapping presses are ignored; the state stays ARMED.
  - ballot_req and close_poll are ignored.
- RECORD (1 cycle):
  - vote_ack = 1, ballot_en = 0, busy = 1.
  - At the end of the cycle, tally[idx] and total_count each increment, saturating at 2^CNT_W − 1.
  - An increment attempted at the maximum value sets sat_flag.
  - Next state is HOLD.
- HOLD:
  - busy = 1, ballot_en = 0.
  - An internal counter runs HOLD_CYCLES cycles, then the state returns to IDLE.
  - Button presses and ballot_req are ignored. A ballot_req held high through HOLD does not re-trigger, because only rising edges are used.
- CLOSED:
  - Terminal until reset; poll_closed = 1, busy = 0.
  - All inputs except rd_sel are ignored.
- Timing (t = cycle the triggering input is sampled high):
  - req_rise at t → ballot_en high from t+1.
  - Valid press at t → vote_ack high at t+1, tally visible at t+2.
  - busy high from t+1 through t+1+HOLD_CYCLES; busy low at t+2+HOLD_CYCLES.
- Read port: rd_count <= tally[rd_sel] every cycle in every state, giving 1-cycle latency. An out-of-range rd_sel returns 0. total_count is a direct register output.
- Reset asserted in any state aborts the ballot immediately and clears all tallies; no partial vote is recorded.

Decomposition:
- Shared package evm_pkg holds:
  - State encoding enum: IDLE, ARMED, RECORD, HOLD, CLOSED.
  - Default constants for NUM_CAND, CNT_W and HOLD_CYCLES.
- One sub-module: tally_bank. It contains the NUM_CAND saturating counters, the total counter, sat_flag, and the registered read mux, with inputs inc_en and inc_idx.
- The FSM and edge detection stay in ballot_controller.

Test Plan:
- Reset, pulse ballot_req, press vote_btn=4'b0010 → ballot_en 1 cycle after req; vote_ack pulse; rd_sel=1 gives rd_count=1; total_count=1; busy low after 8 hold cycles.
- ARMED, vote_btn=4'b0110 in one cycle, then release, then 4'b1000 → no ack for the double press; tally[3]=1, tally[1]=tally[2]=0.
- Press vote_btn=4'b0001 while IDLE and during HOLD → no ack, all tallies unchanged.
- CNT_W=4: cast 16 votes for candidate 0 → tally[0]=15, total=15, sat_flag=1.
- ballot_req and close_poll high together in IDLE → poll_closed=1, ballot_en stays 0; a later req_rise is ignored; the read port still returns prior tallies.
- Assert rst during ARMED and during HOLD → outputs and tallies return to 0 asynchronously; the next ballot works normally.

Source files
------------

// File: rtl/evm_pkg.sv
// Shared types and default sizing for the EVM ballot controller slice.
package evm_pkg;

    // Voting-cycle states of the ballot controller
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        RECORD = 3'd2,
        HOLD   = 3'd3,
        CLOSED = 3'd4
    } state_t;

    // Default build: four candidates, 8-bit tallies, 8-cycle lockout
    localparam int DEF_NUM_CAND    = 4;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_HOLD_CYCLES = 8;

endpackage

// File: rtl/tally_bank.sv
// Per-candidate saturating tallies, total counter, sticky saturation flag
// and the registered result read-out port.
module tally_bank
    import evm_pkg::*;
#(
    parameter int NUM_CAND = DEF_NUM_CAND,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int SEL_W    = $clog2(DEF_NUM_CAND)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    input  logic [SEL_W-1:0] inc_idx,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] total_count,
    output logic             sat_flag
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] tally [NUM_CAND];
    logic             inc_ok;
    logic             rd_ok;

    // Indices beyond the candidate count are treated as non-existent
    assign inc_ok = ({1'b0, inc_idx} < (SEL_W+1)'(NUM_CAND));
    assign rd_ok  = ({1'b0, rd_sel}  < (SEL_W+1)'(NUM_CAND));

    // Count one vote into the chosen tally and the total; a count already at maximum holds and latches sat_flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                tally[i] <= '0;
            end
            total_count <= '0;
            sat_flag    <= 1'b0;
        end else if (inc_en) begin
            if (inc_ok) begin
                if (tally[inc_idx] == CNT_MAX) begin
                    sat_flag <= 1'b1;
                end else begin
                    tally[inc_idx] <= tally[inc_idx] + 1'b1;
                end
            end
            if (total_count == CNT_MAX) begin
                sat_flag <= 1'b1;
            end else begin
                total_count <= total_count + 1'b1;
            end
        end
    end

    // Result read-out register, refreshed every cycle regardless of controller state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
        end else begin
            rd_count <= rd_ok ? tally[rd_sel] : '0;
        end
    end

endmodule

// File: rtl/ballot_controller.sv
// EVM ballot sequencer: issues a ballot on a request edge, accepts exactly
// one clean candidate press, tallies it, then locks the unit for a hold period.
module ballot_controller
    import evm_pkg::*;
#(
    parameter int NUM_CAND    = DEF_NUM_CAND,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ballot_req,
    input  logic                        close_poll,
    input  logic [NUM_CAND-1:0]         vote_btn,
    input  logic [$clog2(NUM_CAND)-1:0] rd_sel,
    output logic                        busy,
    output logic                        ballot_en,
    output logic                        vote_ack,
    output logic                        poll_closed,
    output logic [CNT_W-1:0]            rd_count,
    output logic [CNT_W-1:0]            total_count,
    output logic                        sat_flag
);

    localparam int SEL_W = $clog2(NUM_CAND);
    localparam int HC_W  = $clog2(HOLD_CYCLES + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

    state_t              state;
    state_t              next_state;
    logic                ballot_req_q;
    logic [NUM_CAND-1:0] vote_btn_q;
    logic                req_rise;
    logic [NUM_CAND-1:0] btn_rise;
    logic                press_ok;
    logic [SEL_W-1:0]    press_idx;
    logic [SEL_W-1:0]    idx_q;
    logic [HC_W-1:0]     hold_cnt;
    logic                hold_done;

    assign req_rise  = ballot_req & ~ballot_req_q;
    assign btn_rise  = vote_btn & ~vote_btn_q;
    // A press counts only when a single button has just gone down and no other is held
    assign press_ok  = (btn_rise != '0) && (vote_btn == btn_rise) && $onehot(vote_btn);
    assign hold_done = (hold_cnt == HOLD_LAST);

    // Previous-cycle copies of the request and buttons for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ballot_req_q <= 1'b0;
            vote_btn_q   <= '0;
        end else begin
            ballot_req_q <= ballot_req;
            vote_btn_q   <= vote_btn;
        end
    end

    // Encode the pressed button into a candidate index
    always_comb begin
        press_idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (vote_btn[i]) begin
                press_idx = SEL_W'(i);
            end
        end
    end

    // Capture the accepted candidate so RECORD can tally it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else if (state == ARMED && press_ok) begin
            idx_q <= press_idx;
        end
    end

    // Lockout timer: counts cycles spent in HOLD, idles at zero elsewhere
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state == HOLD) begin
            hold_cnt <= hold_cnt + 1'b1;
        end else begin
            hold_cnt <= '0;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and status outputs; closing the poll wins over a same-cycle ballot request
    always_comb begin
        next_state  = state;
        busy        = 1'b0;
        ballot_en   = 1'b0;
        vote_ack    = 1'b0;
        poll_closed = 1'b0;
        case (state)
            IDLE: begin
                if (close_poll) begin
                    next_state = CLOSED;
                end else if (req_rise) begin
                    next_state = ARMED;
                end
            end
            ARMED: begin
                busy      = 1'b1;
                ballot_en = 1'b1;
                if (press_ok) begin
                    next_state = RECORD;
                end
            end
            RECORD: begin
                busy       = 1'b1;
                vote_ack   = 1'b1;
                next_state = HOLD;
            end
            HOLD: begin
                busy = 1'b1;
                if (hold_done) begin
                    next_state = IDLE;
                end
            end
            CLOSED: begin
                poll_closed = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    tally_bank #(
        .NUM_CAND (NUM_CAND),
        .CNT_W    (CNT_W),
        .SEL_W    (SEL_W)
    ) u_tally_bank (
        .clk         (clk),
        .rst         (rst),
        .inc_en      (state == RECORD),
        .inc_idx     (idx_q),
        .rd_sel      (rd_sel),
        .rd_count    (rd_count),
        .total_count (total_count),
        .sat_flag    (sat_flag)
    );

endmodule
